data_stack: RTL and testbench

//  Operand stack of the comproc CPU datapath, directly downstream of the signals

---
 rtl/data_stack.sv | 120 ++++++++++++
 tb/tb_data_stack.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/data_stack.sv
// Operand stack for the comproc datapath: registered top entry plus a body array,
// exposing the top two entries, the depth and sticky overflow/underflow/illegal-op flags.
module data_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             load_stk,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] stk0,
    output logic [WIDTH-1:0] stk1,
    output logic [CW-1:0]    count,
    output logic             ovf,
    output logic             udf,
    output logic             err_op
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;
    localparam logic [CW-1:0] ZERO = '0;
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] TWO  = CW'(2);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] body [DEPTH-1];

    logic [WIDTH-1:0] top_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             body_we;
    logic             set_ovf;
    logic             set_udf;
    logic             set_err;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    // The entry below the top lives at body[count-2]; a push spills top into body[count-1].
    assign wr_idx = AW'(count - ONE);
    assign rd_idx = AW'(count - TWO);

    always_comb begin
        top_nxt = top;
        cnt_nxt = count;
        body_we = 1'b0;
        set_ovf = 1'b0;
        set_udf = 1'b0;
        set_err = 1'b0;
        unique case ({push, pop, load_stk})
            3'b000: ;
            3'b001: begin
                if (count >= ONE) top_nxt = data_in;
                else              set_udf = 1'b1;
            end
            3'b101: begin
                if (count == FULL) begin
                    set_ovf = 1'b1;
                end else begin
                    body_we = (count != ZERO);
                    top_nxt = data_in;
                    cnt_nxt = count + ONE;
                end
            end
            3'b100: begin
                if (count == FULL) begin
                    set_ovf = 1'b1;
                end else if (count == ZERO) begin
                    set_udf = 1'b1;
                end else begin
                    body_we = 1'b1;
                    cnt_nxt = count + ONE;
                end
            end
            3'b010: begin
                if (count == ZERO) begin
                    set_udf = 1'b1;
                end else begin
                    top_nxt = (count == ONE) ? '0 : body[rd_idx];
                    cnt_nxt = count - ONE;
                end
            end
            3'b011: begin
                if (count < TWO) begin
                    set_udf = 1'b1;
                end else begin
                    top_nxt = data_in;
                    cnt_nxt = count - ONE;
                end
            end
            default: set_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top    <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
            err_op <= 1'b0;
        end else begin
            top    <= top_nxt;
            count  <= cnt_nxt;
            ovf    <= ovf | set_ovf;
            udf    <= udf | set_udf;
            err_op <= err_op | set_err;
        end
    end

    // Body is never reset; entries at or above count are masked from the outputs.
    always_ff @(posedge clk) begin
        if (body_we) body[wr_idx] <= top;
    end

    assign stk0 = (count == ZERO) ? '0 : top;
    assign stk1 = (count >= TWO) ? body[rd_idx] : '0;

endmodule

// File: tb/tb_data_stack.sv
// Scoreboard bench for data_stack: a queue-based reference stack predicts each
// cycle's outputs, which are queued at drive time and compared after the edge.
module tb_data_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             load_stk = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] stk0;
    logic [WIDTH-1:0] stk1;
    logic [CW-1:0]    count;
    logic             ovf;
    logic             udf;
    logic             err_op;

    data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .load_stk(load_stk),
        .data_in(data_in), .stk0(stk0), .stk1(stk1), .count(count),
        .ovf(ovf), .udf(udf), .err_op(err_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] s0;
        logic [WIDTH-1:0] s1;
        logic [CW-1:0]    cnt;
        logic             ovf;
        logic             udf;
        logic             err;
    } exp_t;

    exp_t            exp_q[$];
    logic [WIDTH-1:0] mstk[$];
    bit              movf, mudf, merr;
    int              total = 0;
    int              bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mstk.delete();
        movf = 0; mudf = 0; merr = 0;
    endtask

    task automatic model_step(input logic p, input logic q, input logic l, input logic [WIDTH-1:0] d);
        int sz;
        sz = mstk.size();
        if (p && q) merr = 1;
        else if (p && l) begin
            if (sz == DEPTH) movf = 1; else mstk.push_back(d);
        end else if (p) begin
            if (sz == DEPTH) movf = 1;
            else if (sz == 0) mudf = 1;
            else mstk.push_back(mstk[sz-1]);
        end else if (q && l) begin
            if (sz < 2) mudf = 1;
            else begin
                void'(mstk.pop_back());
                mstk[sz-2] = d;
            end
        end else if (q) begin
            if (sz == 0) mudf = 1; else void'(mstk.pop_back());
        end else if (l) begin
            if (sz == 0) mudf = 1; else mstk[sz-1] = d;
        end
    endtask

    function automatic exp_t model_view();
        exp_t e;
        int sz;
        sz = mstk.size();
        e.s0  = (sz > 0) ? mstk[sz-1] : '0;
        e.s1  = (sz > 1) ? mstk[sz-2] : '0;
        e.cnt = CW'(sz);
        e.ovf = movf;
        e.udf = mudf;
        e.err = merr;
        return e;
    endfunction

    task automatic check_state(input string tag, input exp_t e);
        chk({tag, ".stk0"}, 32'(stk0), 32'(e.s0));
        chk({tag, ".stk1"}, 32'(stk1), 32'(e.s1));
        chk({tag, ".count"}, 32'(count), 32'(e.cnt));
        chk({tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
        chk({tag, ".udf"}, 32'(udf), 32'(e.udf));
        chk({tag, ".err_op"}, 32'(err_op), 32'(e.err));
    endtask

    task automatic do_op(input string tag, input logic p, input logic q, input logic l,
                         input logic [WIDTH-1:0] d);
        @(negedge clk);
        push = p; pop = q; load_stk = l; data_in = d;
        model_step(p, q, l, d);
        exp_q.push_back(model_view());
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; load_stk = 1'b0;
        if (exp_q.size() == 0) begin
            chk({tag, ".queue_empty"}, 32'd1, 32'd0);
        end else begin
            check_state(tag, exp_q.pop_front());
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        // Reset held with push toggling: nothing may move.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            push = ~push;
            load_stk = 1'b1;
            data_in = 16'hFFFF;
            @(posedge clk);
            #1;
            check_state("rst_hold", model_view());
        end
        push = 1'b0; load_stk = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1 check_state("rst_release", model_view());
        do_op("idle", 0, 0, 0, 16'h0);

        // Push immediates then binary op.
        do_op("push_a5", 1, 0, 1, 16'h00A5);
        do_op("push_1234", 1, 0, 1, 16'h1234);
        do_op("binop", 0, 1, 1, 16'h12D9);

        // Pops down to underflow.
        apply_reset();
        do_op("push_a5b", 1, 0, 1, 16'h00A5);
        do_op("push_1234b", 1, 0, 1, 16'h1234);
        do_op("pop1", 0, 1, 0, 16'h0);
        do_op("pop2", 0, 1, 0, 16'h0);
        do_op("pop_udf", 0, 1, 0, 16'h0);
        do_op("load_udf", 0, 0, 1, 16'h5555);

        // Fill to DEPTH, then overflow.
        apply_reset();
        for (int i = 0; i < DEPTH; i++) do_op("fill", 1, 0, 1, 16'(i));
        do_op("push_ovf", 1, 0, 1, 16'hBEEF);
        do_op("dup_ovf", 1, 0, 0, 16'h0);
        do_op("load_full", 0, 0, 1, 16'hCAFE);

        // Drain to count 5 with ovf set, then reset between edges.
        for (int i = 0; i < DEPTH - 5; i++) do_op("drain", 0, 1, 0, 16'h0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_state("async_rst", model_view());
        @(negedge clk);
        rst_n = 1'b1;

        // Duplicate and illegal push+pop.
        do_op("dup_udf", 1, 0, 0, 16'h0);
        apply_reset();
        do_op("push7", 1, 0, 1, 16'h0007);
        do_op("binop_udf", 0, 1, 1, 16'h0009);
        do_op("dup", 1, 0, 0, 16'h0);
        do_op("illegal", 1, 1, 0, 16'h0);
        do_op("illegal_l", 1, 1, 1, 16'h1111);
        do_op("load_top", 0, 0, 1, 16'h0042);

        // Weighted random traffic, with a reset midway to clear sticky flags.
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            int op;
            logic [WIDTH-1:0] d;
            if (i == 200) apply_reset();
            op = $urandom_range(0, 11);
            d = WIDTH'($urandom);
            case (op)
                0, 1, 2, 3: do_op("rnd_pushl", 1, 0, 1, d);
                4:          do_op("rnd_dup", 1, 0, 0, d);
                5, 6:       do_op("rnd_pop", 0, 1, 0, d);
                7, 8:       do_op("rnd_binop", 0, 1, 1, d);
                9:          do_op("rnd_load", 0, 0, 1, d);
                10:         do_op("rnd_hold", 0, 0, 0, d);
                default:    do_op("rnd_illegal", 1, 1, op[0], d);
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
